// File: rtl/neuron_scheduler.sv
// neuron_scheduler: evaluates NUM_NEURONS integrate-and-fire neurons with one shared serial accumulator.
// Optional feature macro NEURON_SAT_EN: accumulator saturates at 2^SUMW-1 instead of wrapping.
`ifndef NUM_SPIKES
`define NUM_SPIKES 4
`endif
`ifndef WBITS
`define WBITS 4
`endif
`ifndef THRESHOLD
`define THRESHOLD 8
`endif

module neuron_scheduler #(
  parameter int          NUM_NEURONS = 4,
  parameter int          SUMW        = 9,
  parameter int unsigned THRESH      = `THRESHOLD,
  localparam int         AW          = (NUM_NEURONS * `NUM_SPIKES > 1) ?
                                       $clog2(NUM_NEURONS * `NUM_SPIKES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   volley_valid,
  output logic                   volley_ready,
  input  logic [`NUM_SPIKES-1:0] spikes_in,
  output logic                   w_rd_en,
  output logic [AW-1:0]          w_rd_addr,
  input  logic [`WBITS-1:0]      w_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] spikes_out,
  output logic                   busy
);

  localparam int S   = `NUM_SPIKES;
  localparam int NS  = NUM_NEURONS * S;
  localparam int KW  = $clog2(NS + 1);
  localparam int SIW = (S > 1) ? $clog2(S) : 1;
  localparam int NW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int XW  = ((SUMW > `WBITS) ? SUMW : `WBITS) + 1;

  localparam logic [KW-1:0]  NS_K    = KW'(NS);
  localparam logic [SIW-1:0] LAST_IN = SIW'(S - 1);
  localparam logic [NW-1:0]  LAST_N  = NW'(NUM_NEURONS - 1);
  localparam logic [XW-1:0]  SAT_X   = {{(XW - SUMW){1'b0}}, {SUMW{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OUT
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [KW-1:0]          k;
  logic [S-1:0]           spikes_q;
  logic                   rd_pend;
  logic [SIW-1:0]         d_in;
  logic [NW-1:0]          d_neuron;
  logic [SUMW-1:0]        acc;
  logic [SUMW-1:0]        acc_next;
  logic [NUM_NEURONS-1:0] result;
  logic [XW-1:0]          term;
  logic [XW-1:0]          base;
  logic [XW-1:0]          wide;
  logic                   fire;
  logic                   accept;
  logic                   issue;
  logic                   last_acc;

  assign accept   = (state == ST_IDLE) && volley_valid;
  assign issue    = (state == ST_RUN) && (k < NS_K);
  assign last_acc = rd_pend && (d_in == LAST_IN) && (d_neuron == LAST_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (volley_valid) state_next = ST_RUN;
      ST_RUN:  if (last_acc)     state_next = ST_OUT;
      ST_OUT:  if (out_ready)    state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Read side: one address per cycle, strictly incrementing from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      spikes_q <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (accept) begin
        k        <= '0;
        spikes_q <= spikes_in;
      end else if (issue) begin
        k <= k + KW'(1);
      end
    end
  end

  // Input index 0 restarts the sum, so no clear is needed between neurons.
  always_comb begin
    term     = '0;
    base     = '0;
    wide     = '0;
    acc_next = acc;
    fire     = 1'b0;
    if (spikes_q[d_in]) term = XW'(w_rd_data);
    if (d_in != '0)     base = XW'(acc);
    wide = base + term;
`ifdef NEURON_SAT_EN
    if (wide > SAT_X) acc_next = '1;
    else              acc_next = wide[SUMW-1:0];
`else
    acc_next = wide[SUMW-1:0];
`endif
    fire = 32'(acc_next) > THRESH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_in     <= '0;
      d_neuron <= '0;
      acc      <= '0;
      result   <= '0;
    end else if (rd_pend) begin
      acc <= acc_next;
      if (d_in == LAST_IN) begin
        result[d_neuron] <= fire;
        d_in             <= '0;
        d_neuron         <= (d_neuron == LAST_N) ? '0 : d_neuron + NW'(1);
      end else begin
        d_in <= d_in + SIW'(1);
      end
    end
  end

  assign volley_ready = (state == ST_IDLE);
  assign w_rd_en      = issue;
  assign w_rd_addr    = issue ? AW'(k) : '0;
  assign out_valid    = (state == ST_OUT);
  assign spikes_out   = result;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler: directed bench, N=2, 4 inputs, 4-bit weights, THRESH=8.
// Two extra SUMW=4 instances exercise overflow; expectations follow NEURON_SAT_EN.
`timescale 1ns/1ps
module tb_neuron_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       volley_valid = 1'b0;
  logic       volley_ready;
  logic [3:0] spikes_in = 4'h0;
  logic       w_rd_en;
  logic [2:0] w_rd_addr;
  logic [3:0] w_rd_data = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] spikes_out;
  logic       busy;

  logic       ovf_valid = 1'b0;
  logic       ovf_ready = 1'b0;
  logic [3:0] ovf_spikes = 4'hF;
  logic [3:0] ovf_wdata = 4'hF;
  logic       ovf_a_vr, ovf_a_en, ovf_a_ov, ovf_a_busy;
  logic       ovf_b_vr, ovf_b_en, ovf_b_ov, ovf_b_busy;
  logic [2:0] ovf_a_addr, ovf_b_addr;
  logic [1:0] ovf_a_out, ovf_b_out;

  logic [3:0] mem [0:7];
  int         checks = 0;
  int         passed = 0;
  int         en_count = 0;
  int         addr_err = 0;
  logic [3:0] next_addr = 4'h0;
  int         lat;

  always #5 clk = ~clk;

  neuron_scheduler #(.NUM_NEURONS(2), .SUMW(9), .THRESH(8)) dut (
    .clk(clk), .rst_n(rst_n), .volley_valid(volley_valid), .volley_ready(volley_ready),
    .spikes_in(spikes_in), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .spikes_out(spikes_out), .busy(busy)
  );

  neuron_scheduler #(.NUM_NEURONS(2), .SUMW(4), .THRESH(8)) ovf_a (
    .clk(clk), .rst_n(rst_n), .volley_valid(ovf_valid), .volley_ready(ovf_a_vr),
    .spikes_in(ovf_spikes), .w_rd_en(ovf_a_en), .w_rd_addr(ovf_a_addr), .w_rd_data(ovf_wdata),
    .out_valid(ovf_a_ov), .out_ready(ovf_ready), .spikes_out(ovf_a_out), .busy(ovf_a_busy)
  );

  neuron_scheduler #(.NUM_NEURONS(2), .SUMW(4), .THRESH(12)) ovf_b (
    .clk(clk), .rst_n(rst_n), .volley_valid(ovf_valid), .volley_ready(ovf_b_vr),
    .spikes_in(ovf_spikes), .w_rd_en(ovf_b_en), .w_rd_addr(ovf_b_addr), .w_rd_data(ovf_wdata),
    .out_valid(ovf_b_ov), .out_ready(ovf_ready), .spikes_out(ovf_b_out), .busy(ovf_b_busy)
  );

  // Weight memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) w_rd_data <= w_rd_en ? mem[w_rd_addr] : 4'hA;

  // Read-stream monitor, restarted at each accepted volley.
  always @(negedge clk) begin
    if (volley_valid && volley_ready) begin
      en_count  = 0;
      addr_err  = 0;
      next_addr = 4'h0;
    end else if (w_rd_en) begin
      if ({1'b0, w_rd_addr} != next_addr) addr_err++;
      next_addr++;
      en_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called at posedge+1; returns the cycle index in which out_valid is first seen.
  task automatic applyStimulus(input logic [31:0] wv, input logic [3:0] spk, input bit poke,
                               output int lat_o);
    for (int i = 0; i < 8; i++) mem[i] = wv[4*i +: 4];
    spikes_in    = spk;
    volley_valid = 1'b1;
    @(posedge clk); #1;
    volley_valid = 1'b0;
    spikes_in    = ~spk;
    lat_o = 1;
    while (!out_valid && lat_o < 40) begin
      volley_valid = poke && (lat_o == 3);
      @(posedge clk); #1;
      lat_o++;
    end
    volley_valid = 1'b0;
  endtask

  task automatic releaseResult(input string tag, input int hold, input logic [1:0] exp);
    for (int h = 0; h < hold; h++) begin
      volley_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, "_hold_out"}, spikes_out, exp);
      checkOutput({tag, "_hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready    = 1'b0;
    volley_valid = 1'b0;
    checkOutput({tag, "_ready_after"}, volley_ready, 1);
    checkOutput({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_volley_ready"}, volley_ready, 1);
    checkOutput({tag, "_w_rd_en"}, w_rd_en, 0);
    checkOutput({tag, "_w_rd_addr"}, w_rd_addr, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_spikes_out"}, spikes_out, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkReset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h11111145, 4'b0011, 1'b0, lat);
    checkOutput("basic_latency", lat, 10);
    checkOutput("basic_out", spikes_out, 2'b01);
    checkOutput("basic_rd_count", en_count, 8);
    checkOutput("basic_addr_err", addr_err, 0);
    releaseResult("basic", 0, 2'b01);

    applyStimulus(32'hFF547735, 4'b0011, 1'b0, lat);
    checkOutput("thresh_latency", lat, 10);
    checkOutput("thresh_out", spikes_out, 2'b10);
    releaseResult("thresh", 0, 2'b10);

    applyStimulus(32'h11111145, 4'b0011, 1'b1, lat);
    checkOutput("bp_latency", lat, 10);
    checkOutput("bp_out", spikes_out, 2'b01);
    checkOutput("bp_rd_count", en_count, 8);
    checkOutput("bp_addr_err", addr_err, 0);
    releaseResult("bp", 5, 2'b01);
    checkOutput("bp_rd_count_after", en_count, 8);

    for (int i = 0; i < 8; i++) mem[i] = 4'hF;
    spikes_in    = 4'b1111;
    volley_valid = 1'b1;
    @(posedge clk); #1;
    volley_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 checkReset("midrun");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h220036FF, 4'b1100, 1'b0, lat);
    checkOutput("recover_latency", lat, 10);
    checkOutput("recover_out", spikes_out, 2'b01);
    checkOutput("recover_rd_count", en_count, 8);
    releaseResult("recover", 0, 2'b01);

    applyStimulus(32'hFFFFFFFF, 4'b0000, 1'b0, lat);
    checkOutput("zero_latency", lat, 10);
    checkOutput("zero_out", spikes_out, 2'b00);
    releaseResult("zero", 0, 2'b00);

    ovf_valid = 1'b1;
    @(posedge clk); #1;
    ovf_valid = 1'b0;
    lat = 1;
    while (!(ovf_a_ov && ovf_b_ov) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("ovf_latency", lat, 10);
    checkOutput("ovf_thresh8_out", ovf_a_out, 2'b11);
`ifdef NEURON_SAT_EN
    checkOutput("ovf_thresh12_out", ovf_b_out, 2'b11);
`else
    checkOutput("ovf_thresh12_out", ovf_b_out, 2'b00);
`endif
    ovf_ready = 1'b1;
    @(posedge clk); #1;
    ovf_ready = 1'b0;
    checkOutput("ovf_ready_after", ovf_a_vr, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
